// File: rtl/obstacle_mem_arbiter.sv
// obstacle_mem_arbiter: shares the single-port obstacle RAM between the CPU
// (Avalon-MM slave) and the renderer's burst line-fetch engine. The renderer
// has priority. A starvation counter gives a waiting CPU one slot after
// CPU_SLOT consecutive burst issues.
module obstacle_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 6,
  parameter int CPU_SLOT = 8
) (
  input  logic                clk,
  input  logic                reset,
  // CPU Avalon-MM slave
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_writedata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  output logic                cpu_waitrequest,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_readdatavalid,
  // renderer burst engine
  input  logic                rd_start,
  input  logic [ADDR_W-1:0]   rd_base,
  input  logic [LEN_W-1:0]    rd_len,
  output logic                rd_busy,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_done,
  // RAM side
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int SC_W = $clog2(CPU_SLOT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_done_q, rd_done_d;

  logic              cpu_req;
  logic              cpu_grant;
  logic              burst_issue;

  assign cpu_req = cpu_read | cpu_write;

  // Next-state and grant decision; reset suppresses every grant so the RAM
  // sees nothing while reset is held.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    starve_d    = starve_q;
    rd_done_d   = 1'b0;
    cpu_grant   = 1'b0;
    burst_issue = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          cpu_grant = cpu_req;
          starve_d  = '0;
          if (rd_start) begin
            if (rd_len != '0) begin
              base_d  = rd_base;
              len_d   = rd_len;
              idx_d   = '0;
              state_d = S_BURST;
            end else begin
              // Empty burst: complete immediately without touching the RAM.
              rd_done_d = 1'b1;
            end
          end
        end
        S_BURST: begin
          if (cpu_req && (starve_q == SC_W'(CPU_SLOT))) begin
            // Guaranteed CPU slot: the burst pauses for this one cycle.
            cpu_grant = 1'b1;
            starve_d  = '0;
          end else begin
            burst_issue = 1'b1;
            starve_d    = cpu_req ? starve_q + 1'b1 : '0;
            idx_d       = idx_q + 1'b1;
            if (idx_q == len_q - 1'b1) begin
              state_d   = S_DRAIN;
              rd_done_d = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          cpu_grant = cpu_req;
          starve_d  = '0;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Read-return tags: data arrives one cycle after the address was issued.
  always_comb begin
    cpu_rvalid_d = cpu_grant & cpu_read;
    rd_valid_d   = burst_issue;
  end

  // State register with synchronous reset; abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      starve_q     <= '0;
      cpu_rvalid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      rd_valid_q   <= rd_valid_d;
      rd_done_q    <= rd_done_d;
    end
  end

  // RAM-side mux: exactly one owner per cycle, all-zero when idle.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = cpu_grant | burst_issue;
    mem_write      = cpu_grant & cpu_write;
    mem_writedata  = '0;
    if (cpu_grant) begin
      mem_address    = cpu_address;
      mem_byteenable = cpu_byteenable;
      if (cpu_write) begin
        mem_writedata = cpu_writedata;
      end
    end else if (burst_issue) begin
      mem_address    = base_q + ADDR_W'(idx_q);
      mem_byteenable = '1;
    end
  end

  // Master-side outputs; read data is forced to zero outside its valid cycle.
  always_comb begin
    cpu_waitrequest   = cpu_req & ~cpu_grant;
    cpu_readdatavalid = cpu_rvalid_q;
    cpu_readdata      = cpu_rvalid_q ? mem_readdata : '0;
    rd_valid          = rd_valid_q;
    rd_data           = rd_valid_q ? mem_readdata : '0;
    rd_done           = rd_done_q;
    rd_busy           = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_obstacle_mem_arbiter.sv
// Directed testbench for obstacle_mem_arbiter with a behavioural 1024x32 RAM.
module tb_obstacle_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  cpu_address = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [3:0]  cpu_byteenable = '0;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic        rd_start = 1'b0;
  logic [9:0]  rd_base = '0;
  logic [5:0]  rd_len = '0;
  logic        rd_busy;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_done;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  int checks = 0;
  int failures = 0;

  obstacle_mem_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_address       (cpu_address),
    .cpu_read          (cpu_read),
    .cpu_write         (cpu_write),
    .cpu_writedata     (cpu_writedata),
    .cpu_byteenable    (cpu_byteenable),
    .cpu_waitrequest   (cpu_waitrequest),
    .cpu_readdata      (cpu_readdata),
    .cpu_readdatavalid (cpu_readdatavalid),
    .rd_start          (rd_start),
    .rd_base           (rd_base),
    .rd_len            (rd_len),
    .rd_busy           (rd_busy),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_done           (rd_done),
    .mem_address       (mem_address),
    .mem_byteenable    (mem_byteenable),
    .mem_chipselect    (mem_chipselect),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_readdata      (mem_readdata)
  );

  always #5 clk = ~clk;

  // Initial RAM contents: a recognisable pattern per address.
  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 | 32'(a & 32'h3FF);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Single-port RAM with registered address: data one cycle after address.
  logic [31:0] ram [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = pat(i);
  end
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  exp_i;
  int  nvalid;
  int  busy_cnt;
  logic prev_v;
  int  prev_a;
  logic slot;
  logic issue;
  int  exp_addr;

  initial begin
    // ---------------- reset, with a CPU read presented during reset
    tick(); reset = 1'b1; cpu_read = 1'b1; cpu_address = 10'h010; #1;
    chk("rst_wait", 32'(cpu_waitrequest), 32'd1);
    chk("rst_cs", 32'(mem_chipselect), 32'd0);
    tick(); reset = 1'b0; cpu_read = 1'b0; #1;
    chk("rst_rdv", 32'(cpu_readdatavalid), 32'd0);
    chk("rst_busy", 32'(rd_busy), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(rd_done), 32'd0);
    chk("rst_wait0", 32'(cpu_waitrequest), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    $display("txn reset done");

    // ---------------- 1: CPU write then read back
    tick(); cpu_write = 1'b1; cpu_address = 10'h010; cpu_writedata = 32'h1234_5678; cpu_byteenable = 4'hF; #1;
    chk("t1_wr_wait", 32'(cpu_waitrequest), 32'd0);
    chk("t1_wr_cs", 32'(mem_chipselect), 32'd1);
    chk("t1_wr_we", 32'(mem_write), 32'd1);
    chk("t1_wr_addr", 32'(mem_address), 32'h010);
    chk("t1_wr_data", mem_writedata, 32'h1234_5678);
    $display("txn cpu_write addr=010 data=12345678");
    tick(); cpu_write = 1'b0; cpu_read = 1'b1; #1;
    chk("t1_rd_wait", 32'(cpu_waitrequest), 32'd0);
    chk("t1_rd_we", 32'(mem_write), 32'd0);
    chk("t1_rd_cs", 32'(mem_chipselect), 32'd1);
    tick(); cpu_read = 1'b0; #1;
    chk("t1_rdv", 32'(cpu_readdatavalid), 32'd1);
    chk("t1_rdata", cpu_readdata, 32'h1234_5678);
    $display("txn cpu_read addr=010 data=%h", cpu_readdata);
    // partial byte-enable write
    tick(); cpu_write = 1'b1; cpu_address = 10'h011; cpu_writedata = 32'hFFFF_FFFF; cpu_byteenable = 4'b0011; #1;
    chk("t1b_be", 32'(mem_byteenable), 32'h3);
    tick(); cpu_write = 1'b0; cpu_read = 1'b1; #1;
    tick(); cpu_read = 1'b0; #1;
    chk("t1b_rdata", cpu_readdata, 32'hA500_FFFF);
    chk("t1b_rdv_drop", 32'(cpu_waitrequest), 32'd0);
    tick(); #1;
    chk("t1b_rdv_off", 32'(cpu_readdatavalid), 32'd0);
    $display("txn cpu_partial_write addr=011 be=3");

    // ---------------- 2: wrapping burst base=3FE len=4
    tick(); rd_start = 1'b1; rd_base = 10'h3FE; rd_len = 6'd4; #1;
    chk("t2_idle_cs", 32'(mem_chipselect), 32'd0);
    chk("t2_idle_busy", 32'(rd_busy), 32'd0);
    busy_cnt = 0;
    for (int k = 0; k <= 5; k++) begin
      tick(); rd_start = 1'b0; #1;
      busy_cnt += int'(rd_busy);
      chk("t2_cs", 32'(mem_chipselect), 32'(k <= 3));
      chk("t2_addr", 32'(mem_address), (k <= 3) ? 32'((10'h3FE + k) & 10'h3FF) : 32'd0);
      chk("t2_valid", 32'(rd_valid), 32'(k >= 1 && k <= 4));
      chk("t2_data", rd_data, (k >= 1 && k <= 4) ? pat(10'h3FE + k - 1) : 32'd0);
      chk("t2_done", 32'(rd_done), 32'(k == 4));
      chk("t2_busy", 32'(rd_busy), 32'(k <= 4));
    end
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd5);
    $display("txn burst base=3fe len=4 busy_cycles=%0d", busy_cnt);

    // ---------------- 3: CPU read held during a len=20 burst
    tick(); rd_start = 1'b1; rd_base = 10'h100; rd_len = 6'd20; #1;
    exp_i = 0; nvalid = 0; prev_v = 1'b0; prev_a = 0;
    for (int k = 1; k <= 23; k++) begin
      tick(); rd_start = 1'b0; cpu_read = (k <= 9); cpu_address = 10'h010; #1;
      slot  = (k == 9);
      issue = (k <= 21) && !slot;
      exp_addr = slot ? 32'h010 : (issue ? 32'h100 + exp_i : 0);
      chk("t3_wait", 32'(cpu_waitrequest), 32'(k <= 8));
      chk("t3_cs", 32'(mem_chipselect), 32'(issue || slot));
      chk("t3_addr", 32'(mem_address), 32'(exp_addr));
      chk("t3_valid", 32'(rd_valid), 32'(prev_v));
      chk("t3_data", rd_data, prev_v ? pat(prev_a) : 32'd0);
      chk("t3_done", 32'(rd_done), 32'(k == 22));
      chk("t3_cpu_rdv", 32'(cpu_readdatavalid), 32'(k == 10));
      chk("t3_cpu_data", cpu_readdata, (k == 10) ? 32'h1234_5678 : 32'd0);
      nvalid += int'(rd_valid);
      prev_v = issue;
      prev_a = 32'h100 + exp_i;
      if (issue) exp_i++;
    end
    chk("t3_nvalid", 32'(nvalid), 32'd20);
    $display("txn burst base=100 len=20 with cpu slot words=%0d", nvalid);

    // ---------------- 4: rd_start and CPU write in the same IDLE cycle
    tick(); rd_start = 1'b1; rd_base = 10'h020; rd_len = 6'd2;
    cpu_write = 1'b1; cpu_address = 10'h030; cpu_writedata = 32'hDEAD_BEEF; cpu_byteenable = 4'hF; #1;
    chk("t4_wait", 32'(cpu_waitrequest), 32'd0);
    chk("t4_we", 32'(mem_write), 32'd1);
    chk("t4_waddr", 32'(mem_address), 32'h030);
    tick(); rd_start = 1'b0; cpu_write = 1'b0; #1;
    chk("t4_busy", 32'(rd_busy), 32'd1);
    chk("t4_first", 32'(mem_address), 32'h020);
    chk("t4_first_cs", 32'(mem_chipselect), 32'd1);
    chk("t4_first_we", 32'(mem_write), 32'd0);
    tick(); #1;
    chk("t4_second", 32'(mem_address), 32'h021);
    tick(); #1;
    chk("t4_done", 32'(rd_done), 32'd1);
    chk("t4_data", rd_data, pat(10'h021));
    $display("txn burst+cpu_write same cycle");

    // ---------------- 5: zero-length burst
    tick(); rd_start = 1'b1; rd_base = 10'h040; rd_len = 6'd0; #1;
    chk("t5_cs0", 32'(mem_chipselect), 32'd0);
    tick(); rd_start = 1'b0; #1;
    chk("t5_done", 32'(rd_done), 32'd1);
    chk("t5_valid", 32'(rd_valid), 32'd0);
    chk("t5_cs1", 32'(mem_chipselect), 32'd0);
    chk("t5_busy", 32'(rd_busy), 32'd0);
    tick(); #1;
    chk("t5_done_off", 32'(rd_done), 32'd0);
    $display("txn burst len=0");

    // ---------------- 6: reset at burst word 3 of 10, then a fresh burst
    tick(); rd_start = 1'b1; rd_base = 10'h200; rd_len = 6'd10; #1;
    for (int k = 1; k <= 3; k++) begin
      tick(); rd_start = 1'b0; #1;
      chk("t6_pre_addr", 32'(mem_address), 32'(10'h200 + k - 1));
    end
    tick(); reset = 1'b1; cpu_read = 1'b1; cpu_address = 10'h010; #1;
    chk("t6_rst_cs", 32'(mem_chipselect), 32'd0);
    chk("t6_rst_wait", 32'(cpu_waitrequest), 32'd1);
    tick(); reset = 1'b0; cpu_read = 1'b0; #1;
    chk("t6_valid", 32'(rd_valid), 32'd0);
    chk("t6_done", 32'(rd_done), 32'd0);
    chk("t6_busy", 32'(rd_busy), 32'd0);
    chk("t6_rdv", 32'(cpu_readdatavalid), 32'd0);
    chk("t6_cs", 32'(mem_chipselect), 32'd0);
    chk("t6_addr", 32'(mem_address), 32'd0);
    chk("t6_rdata", rd_data, 32'd0);
    chk("t6_cdata", cpu_readdata, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("t6_quiet_done", 32'(rd_done), 32'd0);
      chk("t6_quiet_valid", 32'(rd_valid), 32'd0);
    end
    tick(); rd_start = 1'b1; rd_base = 10'h005; rd_len = 6'd2; #1;
    tick(); rd_start = 1'b0; #1;
    chk("t6_new_a0", 32'(mem_address), 32'h005);
    tick(); #1;
    chk("t6_new_a1", 32'(mem_address), 32'h006);
    chk("t6_new_d0", rd_data, pat(10'h005));
    tick(); #1;
    chk("t6_new_done", 32'(rd_done), 32'd1);
    chk("t6_new_d1", rd_data, pat(10'h006));
    tick(); #1;
    chk("t6_new_idle", 32'(rd_busy), 32'd0);
    $display("txn reset mid-burst then burst base=005 len=2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
